// File: rtl/life_sequencer_pkg.sv
// Shared types and constants for the life_sequencer run/pause/step controller.
package life_pkg;

    localparam int GEN_W_DEF   = 32;
    localparam int SPEED_W_DEF = 8;
    localparam int ACK_TIMEOUT = 2;

    typedef enum logic [2:0] {
        ST_PAUSED,
        ST_WAIT_TICK,
        ST_LAUNCH,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } life_seq_state_t;

endpackage

// File: rtl/life_sequencer_frame_pacer.sv
// Frame tick divider: counts frame ticks while enabled and pulses due every max(speed,1) ticks.
module frame_pacer
    import life_pkg::*;
#(
    parameter int SPEED_W = SPEED_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               tick,
    input  logic               clear,
    input  logic               restart,
    input  logic [SPEED_W-1:0] speed,
    output logic               due
);

    localparam logic [SPEED_W:0] ONE = {{SPEED_W{1'b0}}, 1'b1};

    logic [SPEED_W-1:0] cnt_q, cnt_d;
    logic [SPEED_W:0]   cnt_inc;
    logic [SPEED_W:0]   target;

    always_comb begin
        target  = (speed == '0) ? ONE : {1'b0, speed};
        cnt_inc = {1'b0, cnt_q} + ONE;
        due     = 1'b0;
        cnt_d   = cnt_q;
        if (clear || restart) begin
            cnt_d = '0;
        end else if (enable && tick) begin
            // >= so that lowering speed mid-count still fires on the next tick
            if (cnt_inc >= target) begin
                due   = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc[SPEED_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Run/pause/step sequencer launching solver batches on frame ticks and tracking total generations.
// Optional build macro LIFE_SEQUENCER_AUTOSTOP_EN adds stop_at/autostopped for bounded runs.
module life_sequencer
    import life_pkg::*;
#(
    parameter int GEN_W   = GEN_W_DEF,
    parameter int SPEED_W = SPEED_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_run,
    input  logic               cmd_pause,
    input  logic               cmd_step,
    input  logic               cmd_clear,
    input  logic               frame_tick,
    input  logic [SPEED_W-1:0] speed,
    input  logic [GEN_W-1:0]   gens_per_batch,
    output logic               solver_start,
    input  logic               solver_ready,
    output logic [GEN_W-1:0]   solver_generations_count,
    output logic               running,
    output logic               busy,
    output logic [GEN_W-1:0]   generation,
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
    input  logic [GEN_W-1:0]   stop_at,
    output logic               autostopped,
`endif
    output logic               overrun
);

    localparam logic [GEN_W-1:0] GEN_ONE  = {{(GEN_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       ACK_LAST = 2'(ACK_TIMEOUT - 1);

    life_seq_state_t  state_q, state_d;
    logic             running_q, running_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       ack_cnt_q, ack_cnt_d;
    logic [GEN_W-1:0] count_q, count_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [GEN_W-1:0] gen_sum;
    logic             pacer_clear, pacer_restart, pacer_due;
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
    logic             autostop_q, autostop_d;
`endif

    frame_pacer #(.SPEED_W(SPEED_W)) u_pacer (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state_q == ST_WAIT_TICK),
        .tick    (frame_tick),
        .clear   (pacer_clear),
        .restart (pacer_restart),
        .speed   (speed),
        .due     (pacer_due)
    );

    always_comb begin
        state_d       = state_q;
        running_d     = running_q;
        busy_d        = busy_q;
        start_d       = 1'b0;
        overrun_d     = overrun_q;
        ack_cnt_d     = ack_cnt_q;
        count_d       = count_q;
        gen_d         = gen_q;
        gen_sum       = gen_q + count_q;
        pacer_clear   = 1'b0;
        pacer_restart = 1'b0;
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
        autostop_d    = autostop_q;
`endif

        if (start_q) busy_d = 1'b1;
        if (cmd_pause) running_d = 1'b0;
        if (frame_tick && running_q &&
            (state_q inside {ST_LAUNCH, ST_WAIT_ACK, ST_WAIT_DONE})) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_PAUSED: begin
                if (!cmd_pause && cmd_step) begin
                    state_d = ST_LAUNCH;
                end else if (!cmd_pause && cmd_run) begin
                    running_d     = 1'b1;
                    overrun_d     = 1'b0;
                    pacer_restart = 1'b1;
                    state_d       = ST_WAIT_TICK;
                end
                if (cmd_clear) gen_d = '0;
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
                if (cmd_clear || (!cmd_pause && (cmd_step || cmd_run))) autostop_d = 1'b0;
`endif
            end
            ST_WAIT_TICK: begin
                if (cmd_pause) begin
                    pacer_clear = 1'b1;
                    state_d     = ST_PAUSED;
                end else if (pacer_due) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (solver_ready) begin
                    start_d   = 1'b1;
                    count_d   = (gens_per_batch == '0) ? GEN_ONE : gens_per_batch;
                    ack_cnt_d = '0;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // A solver that finishes too fast to ever drop ready is treated as having accepted.
                if (!solver_ready || ack_cnt_q == ACK_LAST) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 2'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (solver_ready) begin
                    gen_d   = gen_sum;
                    busy_d  = 1'b0;
                    state_d = running_d ? ST_WAIT_TICK : ST_PAUSED;
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
                    if (stop_at != '0 && gen_sum >= stop_at) begin
                        running_d  = 1'b0;
                        autostop_d = 1'b1;
                        state_d    = ST_PAUSED;
                    end
`endif
                end
            end
            default: state_d = ST_PAUSED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_PAUSED;
            running_q  <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ack_cnt_q  <= '0;
            count_q    <= '0;
            gen_q      <= '0;
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
            autostop_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            overrun_q  <= overrun_d;
            ack_cnt_q  <= ack_cnt_d;
            count_q    <= count_d;
            gen_q      <= gen_d;
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
            autostop_q <= autostop_d;
`endif
        end
    end

    assign solver_start             = start_q;
    assign solver_generations_count = count_q;
    assign running                  = running_q;
    assign busy                     = busy_q;
    assign generation               = gen_q;
    assign overrun                  = overrun_q;
`ifdef LIFE_SEQUENCER_AUTOSTOP_EN
    assign autostopped              = autostop_q;
`endif

endmodule
